// File: rtl/lif_pkg.sv
// Shared width defaults and the saturating clamp for the LIF neuron membrane update.
package lif_pkg;

  localparam int LIF_DATA_W   = 16;
  localparam int LIF_WEIGHT_W = 8;
  localparam int LIF_THRESH_W = 16;
  localparam int LIF_LEAK_W   = 8;
  localparam int LIF_REFRAC_W = 8;

  // Widest membrane the clamp supports; callers sign-extend into this frame.
  localparam int LIF_MAX_W    = 32;

  function automatic logic [LIF_MAX_W-1:0] sat_clamp(
    input logic signed [LIF_MAX_W+1:0] v,
    input int unsigned                 dw
  );
    logic signed [LIF_MAX_W+1:0] maxv;
    maxv = (34'sd1 <<< dw) - 34'sd1;
    if (v < 0)         return '0;
    else if (v > maxv) return maxv[LIF_MAX_W-1:0];
    else               return v[LIF_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/lif_membrane_update.sv
// Combinational membrane step: leak plus signed synaptic weight, clamped, with fire compare.
module lif_membrane_update
  import lif_pkg::*;
#(
  parameter int DATA_WIDTH      = LIF_DATA_W,
  parameter int WEIGHT_WIDTH    = LIF_WEIGHT_W,
  parameter int THRESHOLD_WIDTH = LIF_THRESH_W,
  parameter int LEAK_WIDTH      = LIF_LEAK_W
) (
  input  logic [DATA_WIDTH-1:0]      mem_i,
  input  logic [LEAK_WIDTH-1:0]      leak_i,
  input  logic                       syn_valid_i,
  input  logic [WEIGHT_WIDTH-1:0]    syn_weight_i,
  input  logic                       syn_exc_i,
  input  logic [THRESHOLD_WIDTH-1:0] threshold_i,
  output logic [DATA_WIDTH-1:0]      v_o,
  output logic                       fire_o
);

  localparam int SW = DATA_WIDTH + 2;

  logic signed [SW-1:0]          v_s;
  logic signed [LIF_MAX_W+1:0]   v_ext;

  always_comb begin
    v_s = $signed(SW'(mem_i)) - $signed(SW'(leak_i));
    if (syn_valid_i) begin
      if (syn_exc_i) v_s = v_s + $signed(SW'(syn_weight_i));
      else           v_s = v_s - $signed(SW'(syn_weight_i));
    end
    v_ext  = (LIF_MAX_W+2)'(v_s);
    v_o    = DATA_WIDTH'(sat_clamp(v_ext, DATA_WIDTH));
    fire_o = (v_o >= DATA_WIDTH'(threshold_i));
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: membrane/spike/refractory registers around the update datapath.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int NEURON_ID       = 0,
  parameter int DATA_WIDTH      = LIF_DATA_W,
  parameter int WEIGHT_WIDTH    = LIF_WEIGHT_W,
  parameter int THRESHOLD_WIDTH = LIF_THRESH_W,
  parameter int LEAK_WIDTH      = LIF_LEAK_W,
  parameter int REFRAC_WIDTH    = LIF_REFRAC_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       syn_valid,
  input  logic [WEIGHT_WIDTH-1:0]    syn_weight,
  input  logic                       syn_excitatory,
  input  logic [THRESHOLD_WIDTH-1:0] threshold,
  input  logic [LEAK_WIDTH-1:0]      leak_rate,
  input  logic [REFRAC_WIDTH-1:0]    refractory_period,
  input  logic                       reset_potential_en,
  input  logic [DATA_WIDTH-1:0]      reset_potential,
  output logic                       spike_out,
  output logic [DATA_WIDTH-1:0]      membrane_potential,
  output logic                       is_refractory,
  output logic [REFRAC_WIDTH-1:0]    refrac_count
);

  // Reject unsupported widths at elaboration; NEURON_ID is trace-only.
  if (THRESHOLD_WIDTH > DATA_WIDTH || DATA_WIDTH > LIF_MAX_W || NEURON_ID < 0) begin : g_bad_cfg
    $error("lif_neuron: unsupported parameter set");
  end

  logic [DATA_WIDTH-1:0]   mem_q, mem_d;
  logic                    spike_q, spike_d;
  logic [REFRAC_WIDTH-1:0] refrac_q, refrac_d;
  logic [DATA_WIDTH-1:0]   v_clamp;
  logic                    fire;

  lif_membrane_update #(
    .DATA_WIDTH      (DATA_WIDTH),
    .WEIGHT_WIDTH    (WEIGHT_WIDTH),
    .THRESHOLD_WIDTH (THRESHOLD_WIDTH),
    .LEAK_WIDTH      (LEAK_WIDTH)
  ) u_update (
    .mem_i        (mem_q),
    .leak_i       (leak_rate),
    .syn_valid_i  (syn_valid),
    .syn_weight_i (syn_weight),
    .syn_exc_i    (syn_excitatory),
    .threshold_i  (threshold),
    .v_o          (v_clamp),
    .fire_o       (fire)
  );

  always_comb begin
    mem_d    = mem_q;
    spike_d  = 1'b0;
    refrac_d = refrac_q;
    if (enable) begin
      // Refractory cycles hold the membrane and drop any input.
      if (refrac_q != '0) begin
        refrac_d = refrac_q - 1'b1;
      end else if (fire) begin
        spike_d  = 1'b1;
        mem_d    = reset_potential_en ? reset_potential : '0;
        refrac_d = refractory_period;
      end else begin
        mem_d = v_clamp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      spike_q  <= 1'b0;
      refrac_q <= '0;
    end else begin
      mem_q    <= mem_d;
      spike_q  <= spike_d;
      refrac_q <= refrac_d;
    end
  end

  assign spike_out          = spike_q;
  assign membrane_potential = mem_q;
  assign refrac_count       = refrac_q;
  assign is_refractory      = (refrac_q != '0);

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron with hand-computed expectations checked by immediate assertions.
module tb_lif_neuron;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        syn_valid;
  logic [7:0]  syn_weight;
  logic        syn_excitatory;
  logic [15:0] threshold;
  logic [7:0]  leak_rate;
  logic [7:0]  refractory_period;
  logic        reset_potential_en;
  logic [15:0] reset_potential;
  logic        spike_out;
  logic [15:0] membrane_potential;
  logic        is_refractory;
  logic [7:0]  refrac_count;

  int n_assert = 0;
  int n_fail   = 0;

  lif_neuron dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .syn_valid          (syn_valid),
    .syn_weight         (syn_weight),
    .syn_excitatory     (syn_excitatory),
    .threshold          (threshold),
    .leak_rate          (leak_rate),
    .refractory_period  (refractory_period),
    .reset_potential_en (reset_potential_en),
    .reset_potential    (reset_potential),
    .spike_out          (spike_out),
    .membrane_potential (membrane_potential),
    .is_refractory      (is_refractory),
    .refrac_count       (refrac_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int mem, input int spk, input int rc);
    chk({tag, ".mem"},   32'(membrane_potential), 32'(mem));
    chk({tag, ".spike"}, 32'(spike_out),          32'(spk));
    chk({tag, ".rc"},    32'(refrac_count),       32'(rc));
    chk({tag, ".refr"},  32'(is_refractory),      32'(rc != 0));
  endtask

  // One clock with an optional event; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [7:0] w, input logic exc);
    syn_valid      = v;
    syn_weight     = w;
    syn_excitatory = exc;
    @(posedge clk);
    #1;
    syn_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; syn_valid = 1'b0; syn_weight = '0; syn_excitatory = 1'b1;
    threshold = 16'h1000; leak_rate = 8'd2; refractory_period = 8'd5;
    reset_potential_en = 1'b0; reset_potential = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 0, 0, 0);
    rst_n = 1'b1;

    // Integration with leak: +32 then four leak cycles of -2 per group.
    enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1, 8'h20, 1'b1);
      repeat (4) cyc(1'b0, 8'h00, 1'b1);
      chk_state($sformatf("leak_grp%0d", k), 22 * k, 0, 0);
    end

    // Threshold crossing, reset to zero, refractory countdown ignoring events.
    pulse_reset();
    threshold = 16'd100; leak_rate = 8'd0;
    cyc(1'b1, 8'h20, 1'b1); chk_state("fire_e1", 32, 0, 0);
    cyc(1'b1, 8'h20, 1'b1); chk_state("fire_e2", 64, 0, 0);
    cyc(1'b1, 8'h20, 1'b1); chk_state("fire_e3", 96, 0, 0);
    cyc(1'b1, 8'h20, 1'b1); chk_state("fire_spk", 0, 1, 5);
    for (int i = 4; i >= 0; i--) begin
      cyc(1'b1, 8'h20, 1'b1);
      chk_state($sformatf("refr%0d", i), 0, 0, i);
    end
    cyc(1'b1, 8'h20, 1'b1); chk_state("post_refr", 32, 0, 0);

    // Same with programmable post-spike potential.
    pulse_reset();
    reset_potential_en = 1'b1; reset_potential = 16'd10;
    repeat (3) cyc(1'b1, 8'h20, 1'b1);
    chk_state("rp_pre", 96, 0, 0);
    cyc(1'b1, 8'h20, 1'b1); chk_state("rp_spk", 10, 1, 5);
    for (int i = 4; i >= 0; i--) begin
      cyc(1'b1, 8'h20, 1'b1);
      chk_state($sformatf("rp_refr%0d", i), 10, 0, i);
    end
    cyc(1'b1, 8'h20, 1'b1); chk_state("rp_post", 42, 0, 0);
    reset_potential_en = 1'b0; reset_potential = '0;

    // Underflow clamps to zero instead of wrapping.
    pulse_reset();
    threshold = 16'h1000; leak_rate = 8'd0;
    cyc(1'b1, 8'd5, 1'b1); chk_state("clamp_set5", 5, 0, 0);
    leak_rate = 8'd2;
    cyc(1'b1, 8'h20, 1'b0); chk_state("clamp_inh", 0, 0, 0);
    leak_rate = 8'd0;
    cyc(1'b1, 8'd1, 1'b1); chk_state("clamp_set1", 1, 0, 0);
    leak_rate = 8'd2;
    cyc(1'b0, 8'd0, 1'b1); chk_state("clamp_leak", 0, 0, 0);

    // Enable low freezes integration and drops events.
    leak_rate = 8'd0;
    cyc(1'b1, 8'h20, 1'b1); chk_state("en_int", 32, 0, 0);
    enable = 1'b0; leak_rate = 8'd2;
    cyc(1'b1, 8'h20, 1'b1); chk_state("en_frz", 32, 0, 0);
    enable = 1'b1; leak_rate = 8'd0; threshold = 16'd40;
    cyc(1'b1, 8'h20, 1'b1); chk_state("en_spk", 0, 1, 5);
    enable = 1'b0;
    cyc(1'b1, 8'h20, 1'b1); chk_state("en_frz_refr", 0, 0, 5);
    enable = 1'b1;
    cyc(1'b0, 8'h00, 1'b1); chk_state("en_resume", 0, 0, 4);

    // Asynchronous reset mid-refractory, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk_state("async_rst", 0, 0, 0);
    rst_n = 1'b1;

    // Zero threshold with no refractory fires on consecutive cycles.
    threshold = 16'd0; refractory_period = 8'd0;
    cyc(1'b0, 8'h00, 1'b1); chk_state("thr0_a", 0, 1, 0);
    cyc(1'b0, 8'h00, 1'b1); chk_state("thr0_b", 0, 1, 0);
    enable = 1'b0;
    cyc(1'b0, 8'h00, 1'b1); chk_state("thr0_off", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no end, expected end of sequence");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Single leaky integrate-and-fire neuron with an unsigned membrane potential.
- Integrates weighted synaptic events and applies a linear leak on every enabled cycle.
- Emits a one-cycle spike on a threshold crossing, then resets the potential and enters a programmable refractory period.
- Leaf block; the neuron array and spike-router layers instantiate it once per neuron.

Parameters:
- NEURON_ID, 0, identifier for debug/trace only; no functional effect.
- DATA_WIDTH, 16, membrane potential and reset potential width (unsigned).
- WEIGHT_WIDTH, 8, synaptic weight magnitude width (unsigned).
- THRESHOLD_WIDTH, 16, threshold width (unsigned; must be <= DATA_WIDTH).
- LEAK_WIDTH, 8, leak decrement width (unsigned).
- REFRAC_WIDTH, 8, refractory counter width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  advance the neuron this cycle; low freezes all state.
- syn_valid  in  1  synaptic event present this cycle.
- syn_weight  in  WEIGHT_WIDTH  event weight magnitude.
- syn_excitatory  in  1  1 = add weight, 0 = subtract weight.
- threshold  in  THRESHOLD_WIDTH  firing threshold.
- leak_rate  in  LEAK_WIDTH  amount subtracted per enabled cycle.
- refractory_period  in  REFRAC_WIDTH  refractory cycles after a spike.
- reset_potential_en  in  1  1 = post-spike value is reset_potential; 0 = post-spike value is 0.
- reset_potential  in  DATA_WIDTH  post-spike membrane value.
- spike_out  out  1  registered one-cycle spike pulse.
- membrane_potential  out  DATA_WIDTH  registered membrane value.
- is_refractory  out  1  high while refrac_count != 0.
- refrac_count  out  REFRAC_WIDTH  remaining refractory cycles.

Behaviour:
- Reset: membrane_potential=0, spike_out=0, refrac_count=0, is_refractory=0.
- enable=0:
  - membrane_potential and refrac_count hold their values.
  - spike_out=0 on the next edge.
  - syn_valid is ignored; events are dropped, not queued.
- Enabled, refrac_count>0:
  - refrac_count decrements by 1.
  - Membrane holds its value; leak and synaptic input are ignored.
  - spike_out=0.
- Enabled, refrac_count=0, integration:
  - v = membrane - leak_rate, then + syn_weight if syn_valid and syn_excitatory, or - syn_weight if syn_valid and not syn_excitatory.
  - Compute at DATA_WIDTH+2 signed; clamp the result to [0, 2^DATA_WIDTH-1].
  - Leak and synaptic input combine in the same cycle.
- Firing condition: clamped v >= threshold (threshold zero-extended).
  - On that edge: spike_out=1, membrane loaded with the post-spike value, refrac_count loaded with refractory_period.
  - Otherwise: membrane = clamped v, spike_out=0.
- Latency: a synaptic event sampled at edge N is visible in membrane_potential and spike_out after edge N.
- spike_out is a single-cycle pulse.
  - The earliest possible next spike is refractory_period+1 cycles later.
  - With refractory_period=0, the neuron can spike on consecutive cycles.
- If reset_potential >= threshold, a re-spike after refractory is permitted; no protection is required.
- threshold=0: the neuron fires on every enabled non-refractory cycle.
- Config inputs are sampled every cycle; changes take effect immediately.
- is_refractory is combinational from the refrac_count register.
- Asserting rst_n low mid-refractory or mid-spike clears everything immediately.

Decomposition:
- Package lif_pkg holds:
  - default width constants;
  - a saturating-clamp function for the membrane update.
- Natural sub-module: lif_membrane_update. Purely combinational; computes clamped v and the fire flag from membrane, leak, weight and sign.
- The top holds the registers and the refractory counter.

Test Plan:
- Reset, then enable with threshold=0x1000, leak=2, refractory=5. Apply 10 single-cycle events of weight 0x20, each followed by 4 idle cycles.
  - Required: net +22 per 5-cycle group; membrane reads 22, 44, … up to 220; no spike.
- threshold=100, leak=0, repeated weight 0x20 events.
  - Required: membrane 32, 64, 96, then spike on the 4th event (128>=100).
  - Required: membrane becomes 0, refrac_count=5 and counts 4,3,2,1,0 with is_refractory high; events during refractory are ignored.
- Same as above with reset_potential_en=1, reset_potential=10.
  - Required: membrane reads 10 after the spike and stays 10 through refractory.
- Membrane=5, leak=2, inhibitory weight 0x20.
  - Required: membrane clamps to 0; leak-only from 1 also gives 0, with no wrap.
- enable=0 mid-integration.
  - Required: membrane and refrac_count frozen; events dropped.
  - Required: asserting rst_n low during refractory clears all outputs asynchronously.
